// File: rtl/subbytes_engine.sv
// -----------------------------------------------------------------------------
// subbytes_engine
//
// Sequential AES SubBytes stage. Accepts one 128-bit state over a valid/ready
// handshake, substitutes LANES bytes per clock through LANES S-box lanes and
// returns the substituted state over a second valid/ready handshake.
//
// Parameters:
//   LANES      parallel S-box lanes: 1, 2, 4, 8 or 16 (anything else fails
//              elaboration). STEPS = 16/LANES processing cycles per state.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data/in_inv valid
//   in_ready   engine idle and able to accept a state
//   in_data    state to substitute; byte 0 = [127:120], byte 15 = [7:0]
//   in_inv     1 = inverse S-box (only honoured with SUBBYTES_INV_SBOX_EN)
//   out_valid  out_data holds a finished state
//   out_ready  consumer accepts out_data
//   out_data   substituted state, same byte order as in_data
//   busy       engine is processing or holding a result
//
// Build option:
//   SUBBYTES_INV_SBOX_EN  when defined, every lane also carries the inverse
//                         table and in_inv selects InvSubBytes. When undefined
//                         only forward tables exist and in_inv is ignored.
// -----------------------------------------------------------------------------
module subbytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup: entry b sits at bit offset 8*(255-b), i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[{~b, 3'b000} +: 8];
  endfunction

`ifdef SUBBYTES_INV_SBOX_EN
  // Inverse S-box, same packing as the forward table.
  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[{~b, 3'b000} +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [127:0]    buf_r;
  logic            mode_r;
  logic            last_step_s;
  logic [127:0]    buf_sub_s;
  logic [3:0]      lane_idx_s [LANES];
  logic [7:0]      lane_in_s  [LANES];
  logic [7:0]      lane_out_s [LANES];

  assign last_step_s = (cnt_r == CW'(STEPS - 1));

  // Per-lane byte selection and substitution for the current step.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Byte index wraps in 4 bits; with LANES=16 the counter is always 0.
    assign lane_idx_s[l] = 4'((int'(cnt_r) * LANES) + l);
    assign lane_in_s[l]  = buf_r[{~lane_idx_s[l], 3'b000} +: 8];
`ifdef SUBBYTES_INV_SBOX_EN
    assign lane_out_s[l] = mode_r ? sbox_inv(lane_in_s[l]) : sbox_fwd(lane_in_s[l]);
`else
    assign lane_out_s[l] = sbox_fwd(lane_in_s[l]);
`endif
  end

`ifndef SUBBYTES_INV_SBOX_EN
  // Mode and in_inv have no consumer when only forward tables are built.
  logic unused_s;
  assign unused_s = ^{in_inv, mode_r};
`endif

  // Merge the substituted lane bytes back into the work buffer image.
  always_comb begin
    buf_sub_s = buf_r;
    for (int l = 0; l < LANES; l++) begin
      buf_sub_s[{~lane_idx_s[l], 3'b000} +: 8] = lane_out_s[l];
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Work buffer, step counter and mode capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_r  <= 128'd0;
      cnt_r  <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            buf_r <= in_data;
            cnt_r <= '0;
`ifdef SUBBYTES_INV_SBOX_EN
            mode_r <= in_inv;
`else
            mode_r <= 1'b0;
`endif
          end
        end
        ST_BUSY: begin
          buf_r <= buf_sub_s;
          if (last_step_s) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          buf_r <= buf_r;
        end
      endcase
    end
  end

  // Handshake and status decodes of the registered state.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign out_data  = buf_r;

endmodule

// File: tb/tb_subbytes_engine.sv
// -----------------------------------------------------------------------------
// tb_subbytes_engine
//
// Self-checking bench for subbytes_engine. Four engines (LANES = 1, 2, 4, 16)
// share clock and reset; stimulus targets one engine at a time. Expected
// states are queued when a state is accepted and compared when the engine
// hands its result to the consumer.
// -----------------------------------------------------------------------------
module tb_subbytes_engine;

  localparam int N_DUT = 4;

  localparam logic [127:0] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SPOT_IN   = 128'hcf4f3c09_00000000_00000000_00000000;
  localparam logic [127:0] SPOT_OUT  = 128'h8a84eb01_63636363_63636363_63636363;
  localparam logic [127:0] ZERO_OUT  = 128'h63636363_63636363_63636363_63636363;
`ifdef SUBBYTES_INV_SBOX_EN
  localparam logic [127:0] INV_EXP   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`else
  localparam logic [127:0] INV_EXP   = 128'h48cc82e4e10846a16c8d4cd972830004;
`endif

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [N_DUT];
  logic         in_ready  [N_DUT];
  logic [127:0] in_data   [N_DUT];
  logic         in_inv    [N_DUT];
  logic         out_valid [N_DUT];
  logic         out_ready [N_DUT];
  logic [127:0] out_data  [N_DUT];
  logic         busy      [N_DUT];

  sb_t exp_q[$];
  int  n_cmp;
  int  n_err;
  int  cyc;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    subbytes_engine #(
      .LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on each output handshake.
  for (genvar g = 0; g < N_DUT; g++) begin : g_mon
    always @(negedge clk) begin
      sb_t e;
      #2;
      if (rst_n && out_valid[g] && out_ready[g]) begin
        chk_eq("sb_nonempty", {127'd0, exp_q.size() != 0}, 128'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_eq("sb_lane", {124'd0, e.idx}, 128'(g));
          chk_eq("sb_data", out_data[g], e.data);
        end
      end
    end
  end

  // Present a state to engine i and return the cycle of the accepting edge.
  task automatic send(input int i, input logic [127:0] d, input logic inv,
                      input logic [127:0] e, input bit push, output int acc);
    int c;
    sb_t s;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_inv[i]   = inv;
    c = 0;
    while (!in_ready[i] && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk_eq("accept_wait", {127'd0, in_ready[i]}, 128'd1);
    if (push) begin
      s.idx  = 4'(i);
      s.data = e;
      exp_q.push_back(s);
    end
    @(negedge clk);
    acc = cyc;
    in_valid[i] = 1'b0;
    in_inv[i]   = 1'b0;
  endtask

  // Count negedges until out_valid is seen (bounded).
  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!out_valid[i] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, lat;
    bit seen;
    sb_t s;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 128'd0;
      in_inv[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end

    // Reset held three edges with in_valid asserted.
    in_valid[2] = 1'b1;
    in_data[2]  = FIPS_IN;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      chk_eq("rst_in_ready",  {127'd0, in_ready[i]},  128'd1);
      chk_eq("rst_out_valid", {127'd0, out_valid[i]}, 128'd0);
      chk_eq("rst_out_data",  out_data[i],            128'd0);
      chk_eq("rst_busy",      {127'd0, busy[i]},      128'd0);
    end
    rst_n  = 1'b1;
    s.idx  = 4'd2;
    s.data = FIPS_OUT;
    exp_q.push_back(s);
    @(negedge clk);
    acc0 = cyc;
    in_valid[2] = 1'b0;
    chk_eq("rel_accept_busy", {127'd0, busy[2]},     128'd1);
    chk_eq("rel_in_ready",    {127'd0, in_ready[2]}, 128'd0);
    wait_valid(2, lat);
    chk_eq("lat_l4", 128'(lat), 128'd4);

    // Back-to-back on LANES=4: accept spacing STEPS+2.
    send(2, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, acc1);
    chk_eq("tput_l4", 128'(acc1 - acc0), 128'd6);
    wait_valid(2, lat);
    chk_eq("lat_l4_b", 128'(lat), 128'd4);

    // LANES=1 spot values.
    send(0, SPOT_IN, 1'b0, SPOT_OUT, 1'b1, acc0);
    wait_valid(0, lat);
    chk_eq("lat_l1", 128'(lat), 128'd16);

    // LANES=16 backpressure.
    out_ready[3] = 1'b0;
    send(3, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, acc0);
    wait_valid(3, lat);
    chk_eq("lat_l16", 128'(lat), 128'd1);
    in_valid[3] = 1'b1;
    in_data[3]  = 128'd0;
    for (int k = 0; k < 10; k++) begin
      chk_eq("bp_out_valid", {127'd0, out_valid[3]}, 128'd1);
      chk_eq("bp_out_data",  out_data[3],            FIPS_OUT);
      chk_eq("bp_in_ready",  {127'd0, in_ready[3]},  128'd0);
      @(negedge clk);
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk_eq("bp_idle_ready", {127'd0, in_ready[3]}, 128'd1);
    chk_eq("bp_idle_busy",  {127'd0, busy[3]},     128'd0);
    s.idx  = 4'd3;
    s.data = ZERO_OUT;
    exp_q.push_back(s);
    @(negedge clk);
    in_valid[3] = 1'b0;
    chk_eq("bp_second_acc", {127'd0, busy[3]}, 128'd1);
    wait_valid(3, lat);
    chk_eq("lat_l16_b", 128'(lat), 128'd1);
    @(negedge clk);

    // LANES=2 reset during the third BUSY cycle.
    send(1, FIPS_IN, 1'b0, FIPS_OUT, 1'b0, acc0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_eq("mrst_in_ready", {127'd0, in_ready[1]}, 128'd1);
    chk_eq("mrst_busy",     {127'd0, busy[1]},     128'd0);
    chk_eq("mrst_buf",      out_data[1],           128'd0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | out_valid[1];
      @(negedge clk);
    end
    chk_eq("mrst_no_valid", {127'd0, seen}, 128'd0);
    send(1, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, acc0);
    wait_valid(1, lat);
    chk_eq("lat_l2", 128'(lat), 128'd8);
    @(negedge clk);

    // Inverse request (forward result when the inverse tables are not built).
    send(2, FIPS_OUT, 1'b1, INV_EXP, 1'b1, acc0);
    wait_valid(2, lat);
    chk_eq("lat_inv", 128'(lat), 128'd4);

    repeat (5) @(negedge clk);
    chk_eq("sb_drain", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
